// File: rtl/ray_dir_gen_pkg.sv
// Fixed-point 3-vector types and helpers shared by the ray generator, plus its FSM state.
// Fixed values are signed 32-bit with FIXED_FRAC_WIDTH fractional bits; Dim[0] is x.
package ray_dir_gen_pkg;

  localparam int FIXED_FRAC_WIDTH = 16;

  typedef struct packed {
    logic signed [31:0] Value;
  } Fixed;

  typedef struct packed {
    Fixed [2:0] Dim;
  } Fixed3;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ISSUE   = 3'd1,
    WAIT    = 3'd2,
    ADVANCE = 3'd3,
    DONE    = 3'd4
  } ray_state_e;

  function automatic Fixed _Fixed(input logic signed [31:0] whole);
    Fixed f;
    f.Value = whole <<< FIXED_FRAC_WIDTH;
    return f;
  endfunction

  function automatic Fixed3 _Fixed3(input Fixed x, input Fixed y, input Fixed z);
    Fixed3 v;
    v.Dim[0] = x;
    v.Dim[1] = y;
    v.Dim[2] = z;
    return v;
  endfunction

  function automatic Fixed3 fixed3_half(input Fixed3 a);
    Fixed3 h;
    for (int i = 0; i < 3; i++) begin
      h.Dim[i].Value = $signed(a.Dim[i].Value) >>> 1;
    end
    return h;
  endfunction

endpackage

// File: rtl/ray_dir_gen_fixed3_add.sv
// Combinational per-Dim Fixed3 adder; two's complement, wraps modulo 2^32.
module Fixed3_Add
  import ray_dir_gen_pkg::*;
(
  input  Fixed3 a,
  input  Fixed3 b,
  output Fixed3 sum
);

  // Independent 32-bit add per dimension, no saturation.
  always_comb begin
    sum = '0;
    for (int i = 0; i < 3; i++) begin
      sum.Dim[i].Value = a.Dim[i].Value + b.Dim[i].Value;
    end
  end

endmodule

// File: rtl/ray_dir_gen.sv
// Walks a SCREEN_W x SCREEN_H frame issuing one unnormalized ray direction per pixel.
// Optional RAYGEN_PIXEL_CENTER_EN offsets the origin by half a step in x and y.
module ray_dir_gen
  import ray_dir_gen_pkg::*;
#(
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120,
  localparam int PXW = (SCREEN_W > 1) ? $clog2(SCREEN_W) : 1,
  localparam int PYW = (SCREEN_H > 1) ? $clog2(SCREEN_H) : 1
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  Fixed3          top_left,
  input  Fixed3          step_x,
  input  Fixed3          step_y,
  output logic           strobe,
  output Fixed3          dir,
  output logic [PXW-1:0] px,
  output logic [PYW-1:0] py,
  input  logic           norm_valid,
  output logic           busy,
  output logic           done
);

  localparam logic [PXW-1:0] PX_LAST = PXW'(SCREEN_W - 1);
  localparam logic [PYW-1:0] PY_LAST = PYW'(SCREEN_H - 1);

  ray_state_e     state_r;
  ray_state_e     next_state_s;
  Fixed3          step_x_r;
  Fixed3          step_y_r;
  Fixed3          row_base_r;
  Fixed3          dir_r;
  Fixed3          add_a_s;
  Fixed3          add_b_s;
  Fixed3          add_sum_s;
  Fixed3          origin_s;
  logic [PXW-1:0] px_r;
  logic [PYW-1:0] py_r;
  logic           strobe_r;
  logic           busy_r;
  logic           done_r;
  logic           px_last_s;
  logic           py_last_s;

  assign px_last_s = (px_r == PX_LAST);
  assign py_last_s = (py_r == PY_LAST);

`ifdef RAYGEN_PIXEL_CENTER_EN
  Fixed3 half_x_s;
  Fixed3 half_y_s;
  Fixed3 center_x_s;

  assign half_x_s = fixed3_half(step_x);
  assign half_y_s = fixed3_half(step_y);

  Fixed3_Add u_center_x (.a(top_left),   .b(half_x_s), .sum(center_x_s));
  Fixed3_Add u_center_y (.a(center_x_s), .b(half_y_s), .sum(origin_s));
`else
  assign origin_s = top_left;
`endif

  // Column steps advance dir; a row wrap advances the row base, which becomes the new dir.
  always_comb begin
    add_a_s = dir_r;
    add_b_s = step_x_r;
    if (px_last_s) begin
      add_a_s = row_base_r;
      add_b_s = step_y_r;
    end else begin
      add_a_s = dir_r;
      add_b_s = step_x_r;
    end
  end

  Fixed3_Add u_step (.a(add_a_s), .b(add_b_s), .sum(add_sum_s));

  // Next-state logic; norm_valid only matters while a request is outstanding.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) next_state_s = ISSUE;
        else       next_state_s = IDLE;
      end
      ISSUE:   next_state_s = WAIT;
      WAIT: begin
        if (norm_valid) begin
          if (px_last_s && py_last_s) next_state_s = DONE;
          else                        next_state_s = ADVANCE;
        end else begin
          next_state_s = WAIT;
        end
      end
      ADVANCE: next_state_s = ISSUE;
      DONE:    next_state_s = IDLE;
      default: next_state_s = IDLE;
    endcase
  end

  // State, registered outputs and the pixel walk; done trails the DONE state by one cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= IDLE;
      strobe_r   <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      px_r       <= '0;
      py_r       <= '0;
      dir_r      <= '0;
      row_base_r <= '0;
      step_x_r   <= '0;
      step_y_r   <= '0;
    end else begin
      state_r  <= next_state_s;
      strobe_r <= (next_state_s == ISSUE);
      busy_r   <= (next_state_s != IDLE);
      done_r   <= (state_r == DONE);
      if ((state_r == IDLE) && start) begin
        step_x_r   <= step_x;
        step_y_r   <= step_y;
        dir_r      <= origin_s;
        row_base_r <= origin_s;
        px_r       <= '0;
        py_r       <= '0;
      end else if (state_r == ADVANCE) begin
        dir_r <= add_sum_s;
        if (px_last_s) begin
          px_r       <= '0;
          py_r       <= py_r + PYW'(1);
          row_base_r <= add_sum_s;
        end else begin
          px_r <= px_r + PXW'(1);
        end
      end else begin
        dir_r <= dir_r;
      end
    end
  end

  assign strobe = strobe_r;
  assign busy   = busy_r;
  assign done   = done_r;
  assign dir    = dir_r;
  assign px     = px_r;
  assign py     = py_r;

endmodule

// File: tb/tb_ray_dir_gen.sv
// Directed bench for ray_dir_gen: 2x2 frames with a latency-3 normalizer model and a 1x1 frame.
module tb_ray_dir_gen;

  logic        clk = 1'b0;
  logic        reset, start, start1;
  logic        norm_valid, norm_valid1;
  logic [95:0] top_left, step_x, step_y;
  logic        strobe, busy, done, strobe1, busy1, done1;
  logic [95:0] dir, dir1;
  logic        px, py, px1, py1;

  int cyc = 0;
  int tests = 0;
  int fails = 0;

  localparam logic [95:0] A_TL = 96'h00010000_00000000_00000000;
  localparam logic [95:0] A_SX = 96'h00000000_00000000_00010000;
  localparam logic [95:0] A_SY = 96'h00000000_FFFF0000_00000000;
  localparam logic [95:0] C_TL = 96'h00000000_00000000_00000001;
  localparam logic [95:0] C_SX = 96'h00000000_00000000_7FFFFFFF;
  localparam logic [95:0] D_TL = 96'h00000004_00000003_00000002;

`ifdef RAYGEN_PIXEL_CENTER_EN
  localparam logic [95:0] EA0 = 96'h00010000_FFFF8000_00008000;
  localparam logic [95:0] EA1 = 96'h00010000_FFFF8000_00018000;
  localparam logic [95:0] EA2 = 96'h00010000_FFFE8000_00008000;
  localparam logic [95:0] EA3 = 96'h00010000_FFFE8000_00018000;
  localparam logic [95:0] EC0 = 96'h00000000_00000000_40000000;
  localparam logic [95:0] EC1 = 96'h00000000_00000000_BFFFFFFF;
`else
  localparam logic [95:0] EA0 = 96'h00010000_00000000_00000000;
  localparam logic [95:0] EA1 = 96'h00010000_00000000_00010000;
  localparam logic [95:0] EA2 = 96'h00010000_FFFF0000_00000000;
  localparam logic [95:0] EA3 = 96'h00010000_FFFF0000_00010000;
  localparam logic [95:0] EC0 = 96'h00000000_00000000_00000001;
  localparam logic [95:0] EC1 = 96'h00000000_00000000_80000000;
`endif

  ray_dir_gen #(.SCREEN_W(2), .SCREEN_H(2)) dut (
    .clk(clk), .reset(reset), .start(start),
    .top_left(top_left), .step_x(step_x), .step_y(step_y),
    .strobe(strobe), .dir(dir), .px(px), .py(py),
    .norm_valid(norm_valid), .busy(busy), .done(done)
  );

  ray_dir_gen #(.SCREEN_W(1), .SCREEN_H(1)) dut1 (
    .clk(clk), .reset(reset), .start(start1),
    .top_left(top_left), .step_x(step_x), .step_y(step_y),
    .strobe(strobe1), .dir(dir1), .px(px1), .py(py1),
    .norm_valid(norm_valid1), .busy(busy1), .done(done1)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Normalizer model: completion pulse 3 cycles after each strobe.
  logic [2:0] nv_pipe  = 3'b000;
  logic [2:0] nv_pipe1 = 3'b000;
  always @(posedge clk) begin
    nv_pipe  <= {nv_pipe[1:0], strobe};
    nv_pipe1 <= {nv_pipe1[1:0], strobe1};
  end
  assign norm_valid  = nv_pipe[2];
  assign norm_valid1 = nv_pipe1[2];

  // Event log sampled on the falling edge.
  logic [95:0] log_dir [0:31];
  int          log_px  [0:31];
  int          log_py  [0:31];
  int          log_cyc [0:31];
  int n_str = 0, n_done = 0, nv_cyc = 0, done_cyc = 0;
  int n_str1 = 0, n_done1 = 0, nv_cyc1 = 0, done_cyc1 = 0, str_cyc1 = 0;
  logic [95:0] dir1_seen = 96'd0;
  int px1_seen = 0, py1_seen = 0;

  always @(negedge clk) begin
    if (strobe && (n_str < 32)) begin
      log_dir[n_str] <= dir;
      log_px[n_str]  <= int'(px);
      log_py[n_str]  <= int'(py);
      log_cyc[n_str] <= cyc;
      n_str          <= n_str + 1;
    end
    if (done)       begin n_done <= n_done + 1; done_cyc <= cyc; end
    if (norm_valid) nv_cyc <= cyc;
    if (strobe1) begin
      n_str1    <= n_str1 + 1;
      str_cyc1  <= cyc;
      dir1_seen <= dir1;
      px1_seen  <= int'(px1);
      py1_seen  <= int'(py1);
    end
    if (done1)       begin n_done1 <= n_done1 + 1; done_cyc1 <= cyc; end
    if (norm_valid1) nv_cyc1 <= cyc;
  end

  task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_strobes(input int target);
    int k = 0;
    while ((n_str < target) && (k < 200)) begin tick(); k++; end
    check("wait_strobe_timeout", 96'(n_str >= target), 96'd1);
  endtask

  task automatic wait_dones(input int target);
    int k = 0;
    while ((n_done < target) && (k < 200)) begin tick(); k++; end
    check("wait_done_timeout", 96'(n_done >= target), 96'd1);
  endtask

  task automatic check_frame(input string tag, input int b, input logic [95:0] e0,
                             input logic [95:0] e1, input logic [95:0] e2, input logic [95:0] e3);
    check({tag, "_dir0"}, log_dir[b],   e0);
    check({tag, "_dir1"}, log_dir[b+1], e1);
    check({tag, "_dir2"}, log_dir[b+2], e2);
    check({tag, "_dir3"}, log_dir[b+3], e3);
    check({tag, "_px0"}, 96'(log_px[b]),   96'd0);
    check({tag, "_px1"}, 96'(log_px[b+1]), 96'd1);
    check({tag, "_px2"}, 96'(log_px[b+2]), 96'd0);
    check({tag, "_px3"}, 96'(log_px[b+3]), 96'd1);
    check({tag, "_py0"}, 96'(log_py[b]),   96'd0);
    check({tag, "_py1"}, 96'(log_py[b+1]), 96'd0);
    check({tag, "_py2"}, 96'(log_py[b+2]), 96'd1);
    check({tag, "_py3"}, 96'(log_py[b+3]), 96'd1);
  endtask

  initial begin
    int base, bdone, start_cyc;
    reset = 1'b1; start = 1'b0; start1 = 1'b0;
    top_left = 96'd0; step_x = 96'd0; step_y = 96'd0;
    repeat (3) tick();

    // Reset state
    check("rst_strobe", 96'(strobe), 96'd0);
    check("rst_busy",   96'(busy),   96'd0);
    check("rst_done",   96'(done),   96'd0);
    check("rst_px",     96'(px),     96'd0);
    check("rst_py",     96'(py),     96'd0);
    check("rst_dir",    dir,         96'd0);
    reset = 1'b0;
    tick();

    // 2x2 frame, second start during WAIT of pixel (1,0), inputs scrambled mid-frame
    base = n_str; bdone = n_done;
    top_left = A_TL; step_x = A_SX; step_y = A_SY;
    start = 1'b1; start_cyc = cyc; tick(); start = 1'b0;
    top_left = 96'hDEADBEEF_12345678_0BADF00D;
    step_x   = 96'h11111111_22222222_33333333;
    step_y   = 96'h44444444_55555555_66666666;
    wait_strobes(base + 2);
    tick();
    check("a_busy_wait", 96'(busy), 96'd1);
    start = 1'b1; tick(); start = 1'b0;
    wait_dones(bdone + 1);
    repeat (4) tick();
    check("a_strobes", 96'(n_str - base), 96'd4);
    check("a_dones",   96'(n_done - bdone), 96'd1);
    check_frame("a", base, EA0, EA1, EA2, EA3);
    check("a_first_lat", 96'(log_cyc[base] - start_cyc), 96'd1);
    check("a_space01", 96'(log_cyc[base+1] - log_cyc[base]),   96'd5);
    check("a_space12", 96'(log_cyc[base+2] - log_cyc[base+1]), 96'd5);
    check("a_space23", 96'(log_cyc[base+3] - log_cyc[base+2]), 96'd5);
    check("a_done_lat", 96'(done_cyc - nv_cyc), 96'd2);
    check("a_busy_end", 96'(busy), 96'd0);

    // Reset in WAIT of the second pixel, then a clean restart
    base = n_str;
    top_left = A_TL; step_x = A_SX; step_y = A_SY;
    start = 1'b1; tick(); start = 1'b0;
    wait_strobes(base + 2);
    tick();
    reset = 1'b1;
    tick();
    check("b_rst_strobe", 96'(strobe), 96'd0);
    check("b_rst_busy",   96'(busy),   96'd0);
    check("b_rst_done",   96'(done),   96'd0);
    check("b_rst_px",     96'(px),     96'd0);
    check("b_rst_py",     96'(py),     96'd0);
    check("b_rst_dir",    dir,         96'd0);
    reset = 1'b0;
    repeat (10) tick();
    check("b_no_more_strobe", 96'(n_str - base), 96'd2);
    check("b_idle_busy", 96'(busy), 96'd0);
    base = n_str; bdone = n_done;
    start = 1'b1; tick(); start = 1'b0;
    wait_dones(bdone + 1);
    repeat (4) tick();
    check("b_strobes", 96'(n_str - base), 96'd4);
    check_frame("b", base, EA0, EA1, EA2, EA3);

    // Wrap-around of Dim[0] without saturation
    base = n_str; bdone = n_done;
    top_left = C_TL; step_x = C_SX; step_y = 96'd0;
    start = 1'b1; tick(); start = 1'b0;
    wait_dones(bdone + 1);
    repeat (4) tick();
    check("c_strobes", 96'(n_str - base), 96'd4);
    check_frame("c", base, EC0, EC1, EC0, EC1);

    // 1x1 frame on the second instance
    top_left = D_TL; step_x = 96'd0; step_y = 96'd0;
    start1 = 1'b1; start_cyc = cyc; tick(); start1 = 1'b0;
    begin
      int k = 0;
      while ((n_done1 < 1) && (k < 200)) begin tick(); k++; end
    end
    repeat (4) tick();
    check("d_strobes",   96'(n_str1), 96'd1);
    check("d_dones",     96'(n_done1), 96'd1);
    check("d_first_lat", 96'(str_cyc1 - start_cyc), 96'd1);
    check("d_nv_lat",    96'(nv_cyc1 - str_cyc1), 96'd3);
    check("d_done_lat",  96'(done_cyc1 - nv_cyc1), 96'd2);
    check("d_dir",       dir1_seen, D_TL);
    check("d_px",        96'(px1_seen), 96'd0);
    check("d_py",        96'(py1_seen), 96'd0);
    check("d_busy_end",  96'(busy1), 96'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ray_dir_gen.md
RAY_DIR_GEN -- requirements
Module: ray_dir_gen

Interface
REQ-001 Parameter SCREEN_W, default 160, pixels per row; SHALL be >= 1.
REQ-002 Parameter SCREEN_H, default 120, rows per frame; SHALL be >= 1.
REQ-003 clk  in  1  sole clock; all state updates on the rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 start  in  1  one-cycle frame request; honoured only in IDLE.
REQ-006 top_left  in  Fixed3  unnormalized direction of pixel (0,0).
REQ-007 step_x  in  Fixed3  direction increment per column.
REQ-008 step_y  in  Fixed3  direction increment per row, downward.
REQ-009 strobe  out  1  one-cycle request to the downstream Fixed3 normalizer.
REQ-010 dir  out  Fixed3  unnormalized ray direction; valid while strobe is high.
REQ-011 px  out  $clog2(SCREEN_W) (min 1)  column of the current dir.
REQ-012 py  out  $clog2(SCREEN_H) (min 1)  row of the current dir.
REQ-013 norm_valid  in  1  normalizer completion pulse for the outstanding request.
REQ-014 busy  out  1  high from the cycle after an accepted start until DONE is exited.
REQ-015 done  out  1  one-cycle pulse after the last pixel's norm_valid.

Function
REQ-016 States: IDLE, ISSUE, WAIT, ADVANCE, DONE.
REQ-017 IDLE + start: latch top_left, step_x, step_y; set row_base = dir = top_left; px = py = 0; go to ISSUE.
REQ-018 ISSUE: strobe = 1 for exactly one cycle; then go to WAIT.
REQ-019 WAIT: hold dir, px, py; on norm_valid, go to DONE if px = SCREEN_W-1 and py = SCREEN_H-1, else go to ADVANCE.
REQ-020 ADVANCE, when px < SCREEN_W-1: px += 1; dir += step_x; go to ISSUE.
REQ-021 ADVANCE, when px = SCREEN_W-1: px = 0; py += 1; row_base += step_y; dir = row_base + step_y; go to ISSUE.
REQ-022 DONE: done = 1 for one cycle; then go to IDLE.
REQ-023 At most one request is outstanding; norm_valid is ignored in IDLE, ISSUE, ADVANCE and DONE.
REQ-024 Per-pixel period = normalizer latency + 2 cycles; first strobe occurs 1 cycle after start.
REQ-025 Arithmetic: per-Dim Fixed .Value addition, two's complement, wraps modulo 2^32, no saturation.
REQ-026 start while busy is ignored; changes to top_left, step_x and step_y mid-frame have no effect.
REQ-027 SCREEN_W = 1 or SCREEN_H = 1 degenerates correctly; a 1x1 frame issues exactly one strobe.

Reset
REQ-028 reset SHALL force IDLE, strobe = 0, busy = 0, done = 0, px = py = 0, dir = 0.
REQ-029 reset SHALL take priority over all other inputs, including mid-frame; no further strobe is issued for the aborted frame.

Configuration
REQ-030 Macro RAYGEN_PIXEL_CENTER_EN: when defined, at start the latched origin SHALL be top_left + (step_x >>> 1) + (step_y >>> 1), using arithmetic shifts; when undefined, the origin is top_left exactly.

Structure
REQ-031 Fixed, Fixed3, FIXED_FRAC_WIDTH and the helpers _Fixed and _Fixed3 come from the shared Fixed3 math package.
REQ-032 The state enum for this block SHALL be added to that package.
REQ-033 The block has one sub-module, Fixed3_Add (combinational per-Dim adder), reused for every increment.

Verification
REQ-034 2x2 frame; top_left = (0,0,1), step_x = (1,0,0), step_y = (0,-1,0); normalizer model latency 3 -> dir sequence (0,0,1), (1,0,1), (0,-1,1), (1,-1,1) with matching px/py; strobe spacing 5 cycles; one done pulse.
REQ-035 start pulsed again during WAIT of pixel (1,0) -> ignored; still exactly 4 strobes and 1 done.
REQ-036 reset asserted in the WAIT of the second pixel -> next cycle IDLE with all outputs 0; a later start restarts at px = py = 0.
REQ-037 RAYGEN_PIXEL_CENTER_EN defined, same stimulus as REQ-034 -> first dir = (0.5,-0.5,1.0).
REQ-038 step_x.Dim[0] = 0x7FFFFFFF, top_left.Dim[0] = 1 -> second dir Dim[0] = 0x80000000 (wrap, no saturation).
REQ-039 1x1 frame -> exactly one strobe, then done 2 cycles after norm_valid.
